// File: rtl/id_pkg.sv
// Shared decode constants for the 10-bit, 8-register pipelined CPU:
// opcodes, jump-select and ALU codes, and the ID/EX control bundle.
package id_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam logic [2:0]  R_LA     = 3'd7;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_JR   = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_LLI  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        JselNone = 2'b00,
        JselBeq  = 2'b01,
        JselBne  = 2'b10,
        JselJmp  = 2'b11
    } jsel_e;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOr  = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic [2:0] reg_writesel;
        logic [1:0] hw_en;
        logic       reg_write_en;
        logic       ram_we;
        logic       imm_sel;
        logic       memtoreg;
        alu_sel_e   alu_sel;
    } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Bundle of the decode stage's fetch/writeback/execute-facing signals.
// slave is the decode stage's view; master is the surrounding pipeline's.
interface id_stage_if #(
    parameter int unsigned DATA_W = 10
) ();
    logic              cache_Ready;
    logic [9:0]        instruction;
    logic [DATA_W-1:0] rs_write_M;
    logic [2:0]        write_sel_M;
    logic              reg_write_en_M;
    logic [DATA_W-1:0] ALU_EX;
    logic [DATA_W-1:0] Mem_M;
    logic [2:0]        write_sel_EX;
    logic              reg_write_en_EX;
    logic              MemtoReg_EX;

    logic [DATA_W-1:0] rs_out;
    logic [DATA_W-1:0] rt_out;
    logic [DATA_W-1:0] signextendimm_out;
    logic [DATA_W-1:0] la_out;
    logic [2:0]        reg_writesel_out;
    logic [2:0]        rd_sel1_out;
    logic [2:0]        rd_sel2_out;
    logic [4:0]        half_word_out;
    logic [1:0]        hw_en_out;
    logic              reg_write_en_out;
    logic              RAM_writeEnable_out;
    logic              imm_sel_out;
    logic              MemtoReg_out;
    logic [1:0]        ALU_sel_out;
    logic              j_cntrl_out;
    logic              PC_en_out;
    logic              PC_hazard;

    modport master (
        output cache_Ready, instruction, rs_write_M, write_sel_M, reg_write_en_M,
               ALU_EX, Mem_M, write_sel_EX, reg_write_en_EX, MemtoReg_EX,
        input  rs_out, rt_out, signextendimm_out, la_out, reg_writesel_out,
               rd_sel1_out, rd_sel2_out, half_word_out, hw_en_out, reg_write_en_out,
               RAM_writeEnable_out, imm_sel_out, MemtoReg_out, ALU_sel_out,
               j_cntrl_out, PC_en_out, PC_hazard
    );

    modport slave (
        input  cache_Ready, instruction, rs_write_M, write_sel_M, reg_write_en_M,
               ALU_EX, Mem_M, write_sel_EX, reg_write_en_EX, MemtoReg_EX,
        output rs_out, rt_out, signextendimm_out, la_out, reg_writesel_out,
               rd_sel1_out, rd_sel2_out, half_word_out, hw_en_out, reg_write_en_out,
               RAM_writeEnable_out, imm_sel_out, MemtoReg_out, ALU_sel_out,
               j_cntrl_out, PC_en_out, PC_hazard
    );
endinterface

// File: rtl/id_hazard_unit.sv
// Load-use / branch hazard detection and branch-operand selection.
// ID_BRANCH_FWD_EN: forward EX/MEM results to branch operands instead of stalling.
module id_hazard_unit
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = 10
) (
    input  logic [2:0]        rd_sel1_i,
    input  logic [2:0]        rd_sel2_i,
    input  jsel_e             jsel_i,
    input  logic [2:0]        idex_sel_i,
    input  logic              idex_we_i,
    input  logic              idex_load_i,
    input  logic [2:0]        ex_sel_i,
    input  logic              ex_we_i,
    input  logic              ex_load_i,
    input  logic [2:0]        m_sel_i,
    input  logic              m_we_i,
    input  logic [DATA_W-1:0] alu_ex_i,
    input  logic [DATA_W-1:0] mem_m_i,
    input  logic [DATA_W-1:0] rf_rd1_i,
    input  logic [DATA_W-1:0] rf_rd2_i,
    output logic              hazard_o,
    output logic [DATA_W-1:0] br_op1_o,
    output logic [DATA_W-1:0] br_op2_o
);

    // r0 is hardwired, so it never creates a dependency.
    function automatic logic src_hit(input logic [2:0] src, input logic [2:0] dst,
                                     input logic we);
        return we && (src == dst) && (src != 3'd0);
    endfunction

    logic idex_hit1, idex_hit2, ex_hit1, ex_hit2;
    logic is_branch, load_use, br_stall;

    assign idex_hit1 = src_hit(rd_sel1_i, idex_sel_i, idex_we_i);
    assign idex_hit2 = src_hit(rd_sel2_i, idex_sel_i, idex_we_i);
    assign ex_hit1   = src_hit(rd_sel1_i, ex_sel_i, ex_we_i);
    assign ex_hit2   = src_hit(rd_sel2_i, ex_sel_i, ex_we_i);
    assign is_branch = (jsel_i != JselNone);
    assign load_use  = idex_load_i && (idex_hit1 || idex_hit2);

`ifdef ID_BRANCH_FWD_EN
    logic m_hit1, m_hit2;

    assign m_hit1   = src_hit(rd_sel1_i, m_sel_i, m_we_i);
    assign m_hit2   = src_hit(rd_sel2_i, m_sel_i, m_we_i);
    // Only results not yet computed (EX loads, anything still in ID/EX) must stall.
    assign br_stall = is_branch &&
                      ((ex_load_i && (ex_hit1 || ex_hit2)) || idex_hit1 || idex_hit2);
    assign br_op1_o = (ex_hit1 && !ex_load_i) ? alu_ex_i : (m_hit1 ? mem_m_i : rf_rd1_i);
    assign br_op2_o = (ex_hit2 && !ex_load_i) ? alu_ex_i : (m_hit2 ? mem_m_i : rf_rd2_i);
`else
    logic unused_fwd;

    assign unused_fwd = ^{ex_load_i, m_sel_i, m_we_i, alu_ex_i, mem_m_i};
    assign br_stall   = is_branch && (ex_hit1 || ex_hit2 || idex_hit1 || idex_hit2);
    assign br_op1_o   = rf_rd1_i;
    assign br_op2_o   = rf_rd2_i;
`endif

    assign hazard_o = load_use || br_stall;

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, 8x10 register file, hazard stall, branch
// resolution and the ID/EX pipeline register. ID_BRANCH_FWD_EN enables branch forwarding.
module id_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = 10
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);

    logic [3:0] op;
    logic [2:0] ra, rb;

    assign op = bus.instruction[9:6];
    assign ra = bus.instruction[5:3];
    assign rb = bus.instruction[2:0];

    ctrl_t ctrl_dec, ctrl_d, ctrl_q;
    jsel_e jsel;
    logic  pc_en;

    always_comb begin
        ctrl_dec              = '0;
        ctrl_dec.reg_writesel = ra;
        ctrl_dec.alu_sel      = AluAdd;
        jsel                  = JselNone;
        pc_en                 = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                ctrl_dec.reg_write_en = 1'b1;
                ctrl_dec.alu_sel      = alu_sel_e'(op[1:0]);
            end
            OP_ADDI: begin
                ctrl_dec.reg_write_en = 1'b1;
                ctrl_dec.imm_sel      = 1'b1;
            end
            OP_LW: begin
                ctrl_dec.reg_write_en = 1'b1;
                ctrl_dec.memtoreg     = 1'b1;
            end
            OP_SW:   ctrl_dec.ram_we = 1'b1;
            OP_BEQ:  jsel = JselBeq;
            OP_BNE:  jsel = JselBne;
            OP_JR:   jsel = JselJmp;
            OP_LUI: begin
                ctrl_dec.reg_writesel = R_LA;
                ctrl_dec.reg_write_en = 1'b1;
                ctrl_dec.hw_en        = 2'b10;
            end
            OP_LLI: begin
                ctrl_dec.reg_writesel = R_LA;
                ctrl_dec.reg_write_en = 1'b1;
                ctrl_dec.hw_en        = 2'b01;
            end
            OP_HALT: pc_en = 1'b0;
            default: ;
        endcase
    end

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_rd1, rf_rd2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.reg_write_en_M && (bus.write_sel_M != 3'd0)) begin
            rf_q[bus.write_sel_M] <= bus.rs_write_M;
        end
    end

    // Write-through so a register written this cycle is read with its new value.
    assign rf_rd1 = (ra == 3'd0) ? '0 :
                    (bus.reg_write_en_M && (bus.write_sel_M == ra)) ? bus.rs_write_M : rf_q[ra];
    assign rf_rd2 = (rb == 3'd0) ? '0 :
                    (bus.reg_write_en_M && (bus.write_sel_M == rb)) ? bus.rs_write_M : rf_q[rb];

    logic              hazard;
    logic [DATA_W-1:0] br_op1, br_op2;

    id_hazard_unit #(
        .DATA_W (DATA_W)
    ) u_hazard (
        .rd_sel1_i   (ra),
        .rd_sel2_i   (rb),
        .jsel_i      (jsel),
        .idex_sel_i  (ctrl_q.reg_writesel),
        .idex_we_i   (ctrl_q.reg_write_en),
        .idex_load_i (ctrl_q.memtoreg),
        .ex_sel_i    (bus.write_sel_EX),
        .ex_we_i     (bus.reg_write_en_EX),
        .ex_load_i   (bus.MemtoReg_EX),
        .m_sel_i     (bus.write_sel_M),
        .m_we_i      (bus.reg_write_en_M),
        .alu_ex_i    (bus.ALU_EX),
        .mem_m_i     (bus.Mem_M),
        .rf_rd1_i    (rf_rd1),
        .rf_rd2_i    (rf_rd2),
        .hazard_o    (hazard),
        .br_op1_o    (br_op1),
        .br_op2_o    (br_op2)
    );

    logic take;

    always_comb begin
        take = 1'b0;
        case (jsel)
            JselBeq: take = (br_op1 == br_op2);
            JselBne: take = (br_op1 != br_op2);
            JselJmp: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    assign bus.j_cntrl_out = take && !hazard;
    assign bus.PC_hazard   = hazard;
    assign bus.PC_en_out   = pc_en;
    assign bus.la_out      = rf_q[R_LA];

    // A stalled instruction enters ID/EX as a bubble with all side effects off.
    always_comb begin
        ctrl_d = ctrl_dec;
        if (hazard) begin
            ctrl_d.reg_write_en = 1'b0;
            ctrl_d.ram_we       = 1'b0;
            ctrl_d.memtoreg     = 1'b0;
        end
    end

    logic [DATA_W-1:0] rs_q, rt_q, imm_q;
    logic [2:0]        sel1_q, sel2_q;
    logic [4:0]        hw_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            sel1_q <= '0;
            sel2_q <= '0;
            hw_q   <= '0;
        end else if (bus.cache_Ready) begin
            ctrl_q <= ctrl_d;
            rs_q   <= rf_rd1;
            rt_q   <= rf_rd2;
            imm_q  <= {{(DATA_W-3){bus.instruction[2]}}, bus.instruction[2:0]};
            sel1_q <= ra;
            sel2_q <= rb;
            hw_q   <= bus.instruction[4:0];
        end
    end

    assign bus.rs_out              = rs_q;
    assign bus.rt_out              = rt_q;
    assign bus.signextendimm_out   = imm_q;
    assign bus.reg_writesel_out    = ctrl_q.reg_writesel;
    assign bus.rd_sel1_out         = sel1_q;
    assign bus.rd_sel2_out         = sel2_q;
    assign bus.half_word_out       = hw_q;
    assign bus.hw_en_out           = ctrl_q.hw_en;
    assign bus.reg_write_en_out    = ctrl_q.reg_write_en;
    assign bus.RAM_writeEnable_out = ctrl_q.ram_we;
    assign bus.imm_sel_out         = ctrl_q.imm_sel;
    assign bus.MemtoReg_out        = ctrl_q.memtoreg;
    assign bus.ALU_sel_out         = ctrl_q.alu_sel;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model.
module tb_id_stage;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(10)) bus ();

    id_stage #(.DATA_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [9:0] rs, rt, imm;
        logic [2:0] wsel, s1, s2;
        logic [4:0] hw;
        logic [1:0] hwen, alu;
        logic       we, ram_we, imm_sel, mtr;
    } exp_t;

    exp_t       m_q;
    logic [9:0] m_rf [8];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [2:0] src, input logic [2:0] dst, input logic we);
        return we && src == dst && src != 3'd0;
    endfunction

    function automatic logic [9:0] m_read(input logic [2:0] idx);
        if (idx == 3'd0) return 10'd0;
        if (bus.reg_write_en_M && bus.write_sel_M == idx) return bus.rs_write_M;
        return m_rf[idx];
    endfunction

`ifdef ID_BRANCH_FWD_EN
    function automatic logic [9:0] m_br_op(input logic [2:0] idx);
        if (m_hit(idx, bus.write_sel_EX, bus.reg_write_en_EX) && !bus.MemtoReg_EX)
            return bus.ALU_EX;
        if (m_hit(idx, bus.write_sel_M, bus.reg_write_en_M)) return bus.Mem_M;
        return m_read(idx);
    endfunction
`endif

    task automatic quiet();
        reset               = 1'b1;
        bus.cache_Ready     = 1'b1;
        bus.instruction     = 10'b1100000000;
        bus.rs_write_M      = '0;
        bus.write_sel_M     = '0;
        bus.reg_write_en_M  = 1'b0;
        bus.ALU_EX          = '0;
        bus.Mem_M           = '0;
        bus.write_sel_EX    = '0;
        bus.reg_write_en_EX = 1'b0;
        bus.MemtoReg_EX     = 1'b0;
    endtask

    // Checks combinational outputs, clocks once, then checks the ID/EX outputs.
    task automatic tick();
        logic [9:0] instr, a, b;
        logic [3:0] op;
        logic [2:0] ra, rb;
        int         jsel;
        bit         idex_any, ex_any, haz, take;
        exp_t       nx;
        #1;
        instr = bus.instruction;
        op = instr[9:6];
        ra = instr[5:3];
        rb = instr[2:0];
        jsel = (op == 4'd7) ? 1 : (op == 4'd8) ? 2 : (op == 4'd9) ? 3 : 0;
        idex_any = m_hit(ra, m_q.wsel, m_q.we) || m_hit(rb, m_q.wsel, m_q.we);
        ex_any = m_hit(ra, bus.write_sel_EX, bus.reg_write_en_EX) ||
                 m_hit(rb, bus.write_sel_EX, bus.reg_write_en_EX);
        haz = m_q.mtr && idex_any;
`ifdef ID_BRANCH_FWD_EN
        if (jsel != 0 && ((ex_any && bus.MemtoReg_EX) || idex_any)) haz = 1;
        a = m_br_op(ra);
        b = m_br_op(rb);
`else
        if (jsel != 0 && (ex_any || idex_any)) haz = 1;
        a = m_read(ra);
        b = m_read(rb);
`endif
        take = !haz && ((jsel == 1 && a == b) || (jsel == 2 && a != b) || jsel == 3);
        check("pc_en", 32'(bus.PC_en_out), 32'(op != 4'hF));
        if (reset) begin
            check("pc_hazard", 32'(bus.PC_hazard), 32'(haz));
            check("j_cntrl", 32'(bus.j_cntrl_out), 32'(take));
            check("la_out", 32'(bus.la_out), 32'(m_rf[7]));
        end
        nx.rs      = m_read(ra);
        nx.rt      = m_read(rb);
        nx.imm     = {{7{instr[2]}}, instr[2:0]};
        nx.s1      = ra;
        nx.s2      = rb;
        nx.hw      = instr[4:0];
        nx.wsel    = (op == 4'hA || op == 4'hB) ? 3'd7 : ra;
        nx.we      = (op <= 4'd5 || op == 4'hA || op == 4'hB) && !haz;
        nx.ram_we  = (op == 4'd6) && !haz;
        nx.mtr     = (op == 4'd5) && !haz;
        nx.imm_sel = (op == 4'd4);
        nx.alu     = (op <= 4'd3) ? op[1:0] : 2'd0;
        nx.hwen    = (op == 4'hA) ? 2'b10 : (op == 4'hB) ? 2'b01 : 2'b00;
        @(posedge clk);
        if (!reset) begin
            m_q = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
        end else begin
            if (bus.cache_Ready) m_q = nx;
            if (bus.reg_write_en_M && bus.write_sel_M != 3'd0) m_rf[bus.write_sel_M] = bus.rs_write_M;
        end
        @(negedge clk);
        check("rs_out", 32'(bus.rs_out), 32'(m_q.rs));
        check("rt_out", 32'(bus.rt_out), 32'(m_q.rt));
        check("imm", 32'(bus.signextendimm_out), 32'(m_q.imm));
        check("wsel", 32'(bus.reg_writesel_out), 32'(m_q.wsel));
        check("sel1", 32'(bus.rd_sel1_out), 32'(m_q.s1));
        check("sel2", 32'(bus.rd_sel2_out), 32'(m_q.s2));
        check("half_word", 32'(bus.half_word_out), 32'(m_q.hw));
        check("hw_en", 32'(bus.hw_en_out), 32'(m_q.hwen));
        check("reg_we", 32'(bus.reg_write_en_out), 32'(m_q.we));
        check("ram_we", 32'(bus.RAM_writeEnable_out), 32'(m_q.ram_we));
        check("imm_sel", 32'(bus.imm_sel_out), 32'(m_q.imm_sel));
        check("memtoreg", 32'(bus.MemtoReg_out), 32'(m_q.mtr));
        check("alu_sel", 32'(bus.ALU_sel_out), 32'(m_q.alu));
    endtask

    initial begin
        m_q = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;

        // Reset, write r1 = 6, then add r2,r1.
        quiet();
        reset = 1'b0;
        bus.instruction = 10'b0000000000;
        tick();
        check("rst_rs", 32'(bus.rs_out), 32'd0);
        check("rst_we", 32'(bus.reg_write_en_out), 32'd0);
        quiet();
        bus.reg_write_en_M = 1'b1;
        bus.write_sel_M = 3'd1;
        bus.rs_write_M = 10'h006;
        tick();
        quiet();
        bus.instruction = 10'b0000010001;
        tick();
        check("add_rs", 32'(bus.rs_out), 32'd0);
        check("add_rt", 32'(bus.rt_out), 32'h006);
        check("add_wsel", 32'(bus.reg_writesel_out), 32'd2);
        check("add_we", 32'(bus.reg_write_en_out), 32'd1);

        // Load-use hazard.
        bus.instruction = 10'b0101010001;
        tick();
        bus.instruction = 10'b0110011010;
        #1;
        check("lu_hazard", 32'(bus.PC_hazard), 32'd1);
        tick();
        check("lu_bubble", 32'(bus.RAM_writeEnable_out), 32'd0);

        // Branch resolution with r1 = 6.
        bus.instruction = 10'b1000001000;
        #1;
        check("bne_taken", 32'(bus.j_cntrl_out), 32'd1);
        tick();
        bus.instruction = 10'b0111001000;
        #1;
        check("beq_not", 32'(bus.j_cntrl_out), 32'd0);
        tick();

        // EX writes r1 with ALU_EX = 0 while beq r1,r0 decodes.
        bus.reg_write_en_EX = 1'b1;
        bus.write_sel_EX = 3'd1;
        bus.ALU_EX = 10'd0;
        #1;
`ifdef ID_BRANCH_FWD_EN
        check("fwd_j", 32'(bus.j_cntrl_out), 32'd1);
        check("fwd_haz", 32'(bus.PC_hazard), 32'd0);
`else
        check("nofwd_j", 32'(bus.j_cntrl_out), 32'd0);
        check("nofwd_haz", 32'(bus.PC_hazard), 32'd1);
`endif
        tick();
        quiet();

        // Hold with cache_Ready low.
        bus.cache_Ready = 1'b0;
        bus.instruction = 10'b0000101110;
        tick();
        check("hold_wsel", 32'(bus.reg_writesel_out), 32'd1);
        check("hold_sel1", 32'(bus.rd_sel1_out), 32'd1);
        bus.cache_Ready = 1'b1;

        // Halt, then lui and its writeback into r7.
        bus.instruction = 10'b1111000000;
        #1;
        check("halt_pc_en", 32'(bus.PC_en_out), 32'd0);
        tick();
        bus.instruction = 10'b1010010101;
        tick();
        check("lui_hw_en", 32'(bus.hw_en_out), 32'd2);
        check("lui_wsel", 32'(bus.reg_writesel_out), 32'd7);
        quiet();
        bus.reg_write_en_M = 1'b1;
        bus.write_sel_M = 3'd7;
        bus.rs_write_M = 10'b1010100000;
        tick();
        check("la_upper", 32'(bus.la_out[9:5]), 32'b10101);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            reset               = ($urandom_range(0, 63) != 0);
            bus.cache_Ready     = ($urandom_range(0, 7) != 0);
            bus.instruction     = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0)
                bus.instruction[9:6] = 4'($urandom_range(7, 9));
            bus.reg_write_en_M  = 1'($urandom_range(0, 1));
            bus.write_sel_M     = 3'($urandom_range(0, 7));
            bus.rs_write_M      = 10'($urandom_range(0, 3));
            bus.Mem_M           = 10'($urandom_range(0, 3));
            bus.ALU_EX          = 10'($urandom_range(0, 3));
            bus.write_sel_EX    = 3'($urandom_range(0, 7));
            bus.reg_write_en_EX = 1'($urandom_range(0, 1));
            bus.MemtoReg_EX     = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name:
id_stage

Overview:
Decode (ID) stage of the 10-bit, 8-register pipelined CPU. It contains five parts: instruction decode, register file, load-use/branch hazard detection, ID-stage branch-operand forwarding and branch resolution. It also contains the ID/EX pipeline register. It sits between fetch (receives instruction; drives PC_en_out, PC_hazard, j_cntrl_out) and execute.

Parameters:
DATA_W, 10, datapath/register width; all encodings below assume 10.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
cache_Ready  in  1  1 = pipeline advances; 0 = ID/EX register holds
instruction  in  10  IF/ID instruction
rs_write_M  in  10  writeback data
write_sel_M  in  3  writeback register index
reg_write_en_M  in  1  writeback enable
ALU_EX  in  10  ALU result currently in EX
Mem_M  in  10  result currently in MEM (load data or ALU)
write_sel_EX  in  3  destination of instruction in EX
reg_write_en_EX  in  1  EX instruction writes a register
MemtoReg_EX  in  1  EX instruction is a load
rs_out  out  10  registered RF read port 1
rt_out  out  10  registered RF read port 2
signextendimm_out  out  10  registered sign-extended instr[2:0]
la_out  out  10  combinational contents of r7 (link/address register)
reg_writesel_out  out  3  registered destination index
rd_sel1_out  out  3  registered source 1 index
rd_sel2_out  out  3  registered source 2 index
half_word_out  out  5  registered instr[4:0]
hw_en_out  out  2  registered {upper_hw_en, lower_hw_en}
reg_write_en_out  out  1  registered register-write enable
RAM_writeEnable_out  out  1  registered store enable
imm_sel_out  out  1  registered ALU-B = immediate select
MemtoReg_out  out  1  registered load flag
ALU_sel_out  out  2  registered ALU op (00 add, 01 sub, 10 and, 11 or)
j_cntrl_out  out  1  combinational: branch/jump taken this cycle
PC_en_out  out  1  combinational: 0 on halt
PC_hazard  out  1  combinational: stall PC and IF/ID

Behaviour:
- Fields: op = instr[9:6], ra = [5:3], rb = [2:0]. rd_sel1 = ra, rd_sel2 = rb.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or: ra = ra op rb.
  - 0100 addi: ra = ra + sext(rb); imm_sel = 1.
  - 0101 lw: ra = mem[rb]; MemtoReg = 1.
  - 0110 sw: mem[rb] = ra.
  - 0111 beq (jsel 01), 1000 bne (jsel 10), 1001 jr rb (jsel 11).
  - 1010 lui: r7[9:5] = instr[4:0]. 1011 lli: r7[4:0] = instr[4:0]. Both: dest 7, reg_write_en = 1.
  - 1111 halt: PC_en = 0.
  - All other opcodes are no-ops: every enable 0.
- Register file: 8 x 10-bit. r0 reads 0 and ignores writes. Write on clk when reg_write_en_M = 1. Same-cycle read of the register being written returns rs_write_M (write-through).
- Hazard compare: a source matches a destination only if the indices are equal, nonzero, and that destination's write enable is 1.
- Load-use hazard: ID/EX holds a load (MemtoReg_out) whose reg_writesel_out matches rd_sel1 or rd_sel2.
- Branch hazard: jsel != 0 and either (a) EX holds a matching instruction with MemtoReg_EX = 1, or (b) ID/EX holds any matching writer.
- On hazard:
  - PC_hazard = 1.
  - reg_write_en, RAM_writeEnable, MemtoReg and jsel are forced to 0 into ID/EX, inserting a bubble.
  - j_cntrl_out = 0.
- Branch operand forwarding, applied per source in priority order:
  - If the source matches EX (non-load), use ALU_EX.
  - Else if it matches write_sel_M, use Mem_M.
  - Else use the RF read.
- Branch resolution: j_cntrl_out = (jsel 01 and ops equal) | (jsel 10 and ops unequal) | (jsel 11). rs_out/rt_out latch raw RF reads; EX-stage forwarding is the execute stage's job.
- ID/EX register:
  - When reset = 0 on a clk edge, all registered outputs clear to 0.
  - Otherwise it loads when cache_Ready = 1 and holds when cache_Ready = 0.
  - Reset has priority over hold.
  - Registered outputs have 1-cycle latency.

Optional Feature:
ID_BRANCH_FWD_EN: when defined, branch operands are forwarded as above and only the listed hazards stall. When undefined, branch operands use raw RF reads and a branch stalls on any match with EX or ID/EX, including non-loads.

Decomposition:
- Shared package id_pkg holds: opcode localparams, jsel codes (NONE/BEQ/BNE/JMP), ALU_sel codes, register count and R_LA = 7.
- Natural sub-module: id_hazard_unit, containing the hazard compares and forwarding selects.

Test Plan:
1. Reset held low 1 cycle -> all registered outputs 0. Then write r1 = 0x006 (wb_en = 1, sel = 1); decode add r2,r1 (0000010001) -> next cycle rs_out = 0, rt_out = 0x006, reg_writesel_out = 2, reg_write_en_out = 1.
2. Load-use hazard: lw r2,[r1] (0101010001), then sw r3,[r2] (0110011010) -> PC_hazard = 1 during sw decode, and the next ID/EX has RAM_writeEnable_out = 0.
3. Branch: r1 = 6, bne r1,r0 (1000001000) with no hazards -> j_cntrl_out = 1 combinationally. beq r1,r0 -> j_cntrl_out = 0.
4. Forwarding (ID_BRANCH_FWD_EN defined): EX writes r1 with ALU_EX = 0, and RF r1 = 6. beq r1,r0 -> j_cntrl_out = 1. With the macro undefined -> PC_hazard = 1 and j_cntrl_out = 0.
5. Hold: cache_Ready = 0 while the instruction changes -> ID/EX outputs unchanged. Halt (1111000000) -> PC_en_out = 0. lui 0b10101 -> after writeback, la_out[9:5] = 10101.
